// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the CPU's HI/LO registers.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MDU_MADD_EN.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_e;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0, OP_MULTU = 4'd1, OP_DIV  = 4'd2, OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4, OP_MTLO  = 4'd5, OP_MADD = 4'd6, OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8, OP_MSUBU = 4'd9
  } op_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        res_q, res_d;
  logic               wr_q, wr_d;
  logic               done_q, done_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;

  // Full-width products; the low 64 bits of the extended operands give the exact result.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'h0, A} * {32'h0, B};

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps instead of overflowing.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, bm_safe;
  logic [31:0] quot_u, rem_u, quot_m, rem_m, quot_s, rem_s;

  assign a_neg   = A[31];
  assign b_neg   = B[31];
  assign a_mag   = a_neg ? (~A + 32'd1) : A;
  assign b_mag   = b_neg ? (~B + 32'd1) : B;
  assign b_safe  = (B == 32'd0) ? 32'd1 : B;
  assign bm_safe = (B == 32'd0) ? 32'd1 : b_mag;
  assign quot_u  = A / b_safe;
  assign rem_u   = A % b_safe;
  assign quot_m  = a_mag / bm_safe;
  assign rem_m   = a_mag % bm_safe;
  assign quot_s  = (a_neg ^ b_neg) ? (~quot_m + 32'd1) : quot_m;
  assign rem_s   = a_neg ? (~rem_m + 32'd1) : rem_m;

  always_comb begin
    // NOTE: every _d signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT:  begin res_d = prod_s; wr_d = 1'b1; cnt_d = CNT_W'(MULT_CYCLES); state_d = RUN; end
            OP_MULTU: begin res_d = prod_u; wr_d = 1'b1; cnt_d = CNT_W'(MULT_CYCLES); state_d = RUN; end
            OP_DIV: begin
              res_d = {rem_s, quot_s}; wr_d = (B != 32'd0);
              cnt_d = CNT_W'(DIV_CYCLES); state_d = RUN;
            end
            OP_DIVU: begin
              res_d = {rem_u, quot_u}; wr_d = (B != 32'd0);
              cnt_d = CNT_W'(DIV_CYCLES); state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
            OP_MADD:  begin res_d = {hi_q, lo_q} + prod_s; wr_d = 1'b1; cnt_d = CNT_W'(MULT_CYCLES); state_d = RUN; end
            OP_MADDU: begin res_d = {hi_q, lo_q} + prod_u; wr_d = 1'b1; cnt_d = CNT_W'(MULT_CYCLES); state_d = RUN; end
            OP_MSUB:  begin res_d = {hi_q, lo_q} - prod_s; wr_d = 1'b1; cnt_d = CNT_W'(MULT_CYCLES); state_d = RUN; end
            OP_MSUBU: begin res_d = {hi_q, lo_q} - prod_u; wr_d = 1'b1; cnt_d = CNT_W'(MULT_CYCLES); state_d = RUN; end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (wr_q) {hi_d, lo_d} = res_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
